pc_sequencer: RTL

Parametrised successor to the single-outstanding PC driver used around `pipeline`. It generates a program counter, issues it to a pipeline over the DIR/DOR/ack handshake with up to MAX_INFLIGHT requests in flight, and supports redirect with discard of wrong-path results. Returned data is buffered in a result FIFO with a valid/ready consumer port. It sits between the control logic and the instruction pipeline.

---
 rtl/pc_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC issue sequencer with multiple outstanding requests, redirect discard and result FIFO
module pc_sequencer #(
  parameter int PC_WIDTH     = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int PC_RESET     = 1,
  parameter int PC_STEP      = 1,
  parameter int MAX_INFLIGHT = 2,
  parameter int RESULT_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic                              redirect_valid,
  input  logic [PC_WIDTH-1:0]               redirect_pc,
  output logic                              pipe_dir,
  output logic [PC_WIDTH-1:0]               pipe_data_in,
  input  logic                              pipe_dor,
  input  logic [DATA_WIDTH-1:0]             pipe_data_out,
  output logic                              pipe_ack,
  output logic                              res_valid,
  output logic [DATA_WIDTH-1:0]             res_data,
  input  logic                              res_ready,
  output logic [PC_WIDTH-1:0]               pc,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err_spurious
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int AW = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int CW = $clog2(RESULT_DEPTH + 1);
  localparam logic [PC_WIDTH-1:0] PC_RST   = PC_WIDTH'(PC_RESET);
  localparam logic [PC_WIDTH-1:0] PC_INC   = PC_WIDTH'(PC_STEP);
  localparam logic [31:0]         MAX_IF   = 32'(MAX_INFLIGHT);
  localparam logic [31:0]         DEPTH    = 32'(RESULT_DEPTH);
  localparam logic [AW-1:0]       LAST_PTR = AW'(RESULT_DEPTH - 1);

  typedef enum logic {WAIT_DOR, ACKING} cpl_state_t;

  cpl_state_t            state;
  logic [DATA_WIDTH-1:0] fifo_mem [RESULT_DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [CW-1:0]         fifo_count;
  logic [IW-1:0]         discard;

  logic issue;
  logic accept;
  logic accept_live;
  logic push;
  logic pop;

  // Credits cover both outstanding requests and buffered results, so a push always has room.
  always_comb begin
    issue = enable && !redirect_valid &&
            (32'(inflight) < MAX_IF) &&
            ((32'(inflight) + 32'(fifo_count)) < DEPTH);
    accept      = (state == WAIT_DOR) && pipe_dor;
    accept_live = accept && (inflight != '0);
    push        = accept_live && (discard == '0) && !redirect_valid;
    pop         = res_valid && res_ready && !redirect_valid;
  end

  assign res_valid = (fifo_count != '0);
  assign res_data  = res_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= pipe_data_out;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= PC_RST;
      pipe_dir     <= 1'b0;
      pipe_data_in <= '0;
      pipe_ack     <= 1'b0;
      inflight     <= '0;
      discard      <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fifo_count   <= '0;
      err_spurious <= 1'b0;
      state        <= WAIT_DOR;
    end else begin
      if (issue) begin
        pipe_dir     <= 1'b1;
        pipe_data_in <= pc;
        pc           <= pc + PC_INC;
      end else begin
        pipe_dir <= 1'b0;
      end
      if (redirect_valid) begin
        pc <= redirect_pc;
      end

      inflight <= inflight + IW'(issue) - IW'(accept_live);

      case (state)
        WAIT_DOR: begin
          if (pipe_dor) begin
            pipe_ack <= 1'b1;
            state    <= ACKING;
            if (inflight == '0) begin
              err_spurious <= 1'b1;
            end
          end
        end
        default: begin
          pipe_ack <= 1'b0;
          state    <= WAIT_DOR;
        end
      endcase

      // Everything still outstanding at a redirect belongs to the wrong path.
      if (redirect_valid) begin
        discard <= inflight - IW'(accept_live);
      end else if (accept_live && (discard != '0)) begin
        discard <= discard - 1'b1;
      end

      if (redirect_valid) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) begin
          wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
